irq_stim_gen: RTL and testbench

- Multi-channel interrupt stimulus generator for the CPU testbench environment.
- Each channel watches the CPU's macroscopic PC for a programmable trigger address and raises an interrupt line.
- The line drops either when the handler stores to that channel's acknowledge address (level mode) or after a fixed number of cycles (pulse mode).
- Channels can re-arm and fire up to a programmable count. The block sits beside the CPU top and drives its external interrupt inputs.

---
 rtl/irq_stim_gen.sv | 159 +++++++++++++++
 tb/tb_irq_stim_gen.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/irq_stim_gen.sv
// Multi-channel interrupt stimulus generator.
// Each channel watches the CPU's macroscopic PC for a trigger word address and
// raises its interrupt line. The line drops when the handler stores to the
// channel's acknowledge word (level mode), or after PULSE_LEN cycles (pulse
// mode). A channel re-arms only after the PC has left the trigger. It retires
// once it has fired MAX_FIRES times; MAX_FIRES = 0 means it never retires.
//
// Channel state encoding, for checkers and waveform viewing:
//   ARMED      = 2'd0
//   ASSERT     = 2'd1
//   WAIT_LEAVE = 2'd2
//   DONE       = 2'd3
// Channel i's state is held in state_q[i].
module irq_stim_gen #(
  parameter int          N_CH      = 2,
  parameter logic [31:0] ACK_BASE  = 32'h0000_7F20,
  parameter int          PULSE_LEN = 4,
  parameter int          MAX_FIRES = 1,
  parameter int          CNT_W     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           macroscopic_pc,
  input  logic [31:0]           m_data_addr,
  input  logic [3:0]            m_data_byteen,
  input  logic [N_CH*32-1:0]    cfg_trig_pc,
  input  logic [N_CH-1:0]       cfg_mode,
  input  logic [N_CH-1:0]       cfg_en,
  output logic [N_CH-1:0]       irq,
  output logic                  irq_any,
  output logic [2:0]            irq_id,
  output logic [N_CH*CNT_W-1:0] fire_cnt,
  output logic                  busy
);

  // The pulse counter only has to hold PULSE_LEN-1.
  localparam int PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
  localparam logic [PW-1:0] PULSE_LOAD = PW'(PULSE_LEN - 1);

  typedef enum logic [1:0] {
    ARMED      = 2'd0,
    ASSERT     = 2'd1,
    WAIT_LEAVE = 2'd2,
    DONE       = 2'd3
  } ch_state_e;

  ch_state_e        state_q [N_CH];
  ch_state_e        state_d [N_CH];
  logic [CNT_W-1:0] cnt_q   [N_CH];
  logic [CNT_W-1:0] cnt_d   [N_CH];
  logic [PW-1:0]    pulse_q [N_CH];
  logic [PW-1:0]    pulse_d [N_CH];
  logic [N_CH-1:0]  irq_q, irq_d;
  logic [N_CH-1:0]  mode_q, mode_d;
  logic [N_CH-1:0]  hit, ack;
  logic [31:0]      pc_w, ack_w;

  // Word-aligned compare of the PC against each trigger, and of the store
  // address against each channel's acknowledge word.
  always_comb begin
    pc_w  = macroscopic_pc & ~32'h3;
    ack_w = m_data_addr & ~32'h3;
    hit   = '0;
    ack   = '0;
    for (int i = 0; i < N_CH; i++) begin
      hit[i] = cfg_en[i] && (pc_w == (cfg_trig_pc[32*i +: 32] & ~32'h3));
      ack[i] = (m_data_byteen != 4'h0) &&
               (ack_w == ((ACK_BASE + 32'(4*i)) & ~32'h3));
    end
  end

  // Per-channel next state. The pulse mode is latched when the channel fires,
  // so changes to cfg_mode or cfg_en while asserted have no effect.
  always_comb begin
    irq_d  = irq_q;
    mode_d = mode_q;
    for (int i = 0; i < N_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      pulse_d[i] = pulse_q[i];
      case (state_q[i])
        ARMED: begin
          if (hit[i]) begin
            state_d[i] = ASSERT;
            irq_d[i]   = 1'b1;
            mode_d[i]  = cfg_mode[i];
            pulse_d[i] = PULSE_LOAD;
            if (cnt_q[i] != '1) cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        ASSERT: begin
          if (mode_q[i]) begin
            if (pulse_q[i] == '0 || ack[i]) begin
              state_d[i] = WAIT_LEAVE;
              irq_d[i]   = 1'b0;
            end else begin
              pulse_d[i] = pulse_q[i] - 1'b1;
            end
          end else if (ack[i]) begin
            state_d[i] = WAIT_LEAVE;
            irq_d[i]   = 1'b0;
          end
        end
        WAIT_LEAVE: begin
          // Hold here while the PC sits on the trigger so that one visit
          // cannot fire the channel more than once.
          if (!hit[i]) begin
            if (MAX_FIRES != 0 && 32'(cnt_q[i]) >= 32'(MAX_FIRES))
              state_d[i] = DONE;
            else
              state_d[i] = ARMED;
          end
        end
        default: begin
          state_d[i] = DONE;
          irq_d[i]   = 1'b0;
        end
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q  <= '0;
      mode_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= ARMED;
        cnt_q[i]   <= '0;
        pulse_q[i] <= '0;
      end
    end else begin
      irq_q  <= irq_d;
      mode_q <= mode_d;
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        pulse_q[i] <= pulse_d[i];
      end
    end
  end

  // Summary outputs, derived from registered state only.
  always_comb begin
    irq      = irq_q;
    irq_any  = |irq_q;
    irq_id   = 3'd0;
    busy     = 1'b0;
    fire_cnt = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (irq_q[i]) irq_id = 3'(i);
    end
    for (int i = 0; i < N_CH; i++) begin
      if (state_q[i] == ASSERT || state_q[i] == WAIT_LEAVE) busy = 1'b1;
      fire_cnt[CNT_W*i +: CNT_W] = cnt_q[i];
    end
  end

endmodule

// File: tb/tb_irq_stim_gen.sv
// Directed bench for irq_stim_gen.
// dut_a has two level-mode channels and retires each channel after one fire.
// dut_b has a single pulse-mode channel that never retires.
// Expected outputs are tracked by hand in the e_* variables as the steps are
// written. Each step pushes the expected output for the coming edge, then pops
// it and compares after that edge.
module tb_irq_stim_gen;

  localparam int W = 37;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc, daddr;
  logic [3:0]  byteen;
  logic [63:0] trig_a;
  logic [1:0]  mode_a, en_a;
  logic [31:0] trig_b;
  logic [0:0]  mode_b, en_b;

  logic [1:0]  irq_a;
  logic        irq_any_a, busy_a;
  logic [2:0]  irq_id_a;
  logic [15:0] fire_cnt_a;
  logic [0:0]  irq_b;
  logic        irq_any_b, busy_b;
  logic [2:0]  irq_id_b;
  logic [7:0]  fire_cnt_b;

  // Expected-state shadows.
  logic [1:0]  e_irq_a;
  logic [7:0]  e_cnt_a0, e_cnt_a1;
  logic        e_busy_a;
  logic        e_irq_b, e_busy_b;
  logic [7:0]  e_cnt_b;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  irq_stim_gen #(.N_CH(2), .PULSE_LEN(4), .MAX_FIRES(1), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .macroscopic_pc(pc), .m_data_addr(daddr),
    .m_data_byteen(byteen), .cfg_trig_pc(trig_a), .cfg_mode(mode_a),
    .cfg_en(en_a), .irq(irq_a), .irq_any(irq_any_a), .irq_id(irq_id_a),
    .fire_cnt(fire_cnt_a), .busy(busy_a)
  );

  irq_stim_gen #(.N_CH(1), .PULSE_LEN(4), .MAX_FIRES(0), .CNT_W(8)) dut_b (
    .clk(clk), .reset(reset), .macroscopic_pc(pc), .m_data_addr(daddr),
    .m_data_byteen(byteen), .cfg_trig_pc(trig_b), .cfg_mode(mode_b),
    .cfg_en(en_b), .irq(irq_b), .irq_any(irq_any_b), .irq_id(irq_id_b),
    .fire_cnt(fire_cnt_b), .busy(busy_b)
  );

  // Clock.
  always #5 clk = ~clk;

  function automatic logic [W-1:0] exp_vec();
    logic       any_a;
    logic [2:0] id_a;
    any_a = |e_irq_a;
    id_a  = e_irq_a[0] ? 3'd0 : (e_irq_a[1] ? 3'd1 : 3'd0);
    return {e_irq_a, any_a, id_a, e_busy_a, e_cnt_a1, e_cnt_a0,
            e_irq_b, e_irq_b, 3'd0, e_busy_b, e_cnt_b};
  endfunction

  // Drive one clock edge with the inputs as currently set and check the result.
  task automatic step(input string tag);
    logic [W-1:0] got, exp;
    exp_q.push_back(exp_vec());
    @(posedge clk);
    #1;
    got = {irq_a, irq_any_a, irq_id_a, busy_a, fire_cnt_a,
           irq_b, irq_any_b, irq_id_b, busy_b, fire_cnt_b};
    exp = exp_q.pop_front();
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic clear_exp();
    e_irq_a = '0; e_cnt_a0 = '0; e_cnt_a1 = '0; e_busy_a = 1'b0;
    e_irq_b = 1'b0; e_busy_b = 1'b0; e_cnt_b = '0;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    clear_exp();
    step(tag);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; pc = 32'h0; daddr = 32'h0; byteen = 4'h0;
    trig_a = '0; mode_a = 2'b00; en_a = 2'b00;
    trig_b = 32'h0; mode_b = 1'b0; en_b = 1'b0;
    clear_exp();
    step("reset0");
    do_reset("reset1");

    // Level mode, single fire, no refire on revisit.
    trig_a[31:0] = 32'h3024; en_a = 2'b01;
    pc = 32'h1000; step("t1_idle");
    pc = 32'h3024; e_irq_a = 2'b01; e_cnt_a0 = 8'd1; e_busy_a = 1'b1;
    step("t1_rise");
    pc = 32'h3028; step("t1_hold");
    daddr = 32'h7F20; byteen = 4'hF; e_irq_a = 2'b00; step("t1_ack");
    byteen = 4'h0; e_busy_a = 1'b0; step("t1_retire");
    pc = 32'h3024; step("t1_revisit0");
    step("t1_revisit1");

    // Pulse mode on dut_b: four cycles high, one pulse per visit.
    en_a = 2'b00;
    trig_b = 32'h5000; mode_b = 1'b1; en_b = 1'b1;
    pc = 32'h5000; e_irq_b = 1'b1; e_cnt_b = 8'd1; e_busy_b = 1'b1;
    step("t2_pulse1_c1");
    step("t2_pulse1_c2");
    step("t2_pulse1_c3");
    step("t2_pulse1_c4");
    e_irq_b = 1'b0;
    for (int i = 0; i < 6; i++) step("t2_held_low");
    pc = 32'h6000; e_busy_b = 1'b0; step("t2_leave");
    pc = 32'h5000; e_irq_b = 1'b1; e_cnt_b = 8'd2; e_busy_b = 1'b1;
    step("t2_pulse2_c1");
    step("t2_pulse2_c2");
    step("t2_pulse2_c3");
    step("t2_pulse2_c4");
    e_irq_b = 1'b0; step("t2_pulse2_end");
    pc = 32'h6000; e_busy_b = 1'b0; step("t2_rearm");
    en_b = 1'b0;
    do_reset("reset2");

    // Two channels on the same trigger, acked in reverse order.
    trig_a = {32'h3000, 32'h3000}; en_a = 2'b11; mode_a = 2'b00;
    pc = 32'h3000; e_irq_a = 2'b11; e_cnt_a0 = 8'd1; e_cnt_a1 = 8'd1;
    e_busy_a = 1'b1; step("t3_both_rise");
    pc = 32'h0100; step("t3_both_hold");
    daddr = 32'h7F24; byteen = 4'hF; e_irq_a = 2'b01; step("t3_ack_ch1");
    byteen = 4'h0; step("t3_ch1_retire");
    daddr = 32'h7F20; byteen = 4'hF; e_irq_a = 2'b00; step("t3_ack_ch0");
    byteen = 4'h0; e_busy_a = 1'b0; step("t3_ch0_retire");
    do_reset("reset3");

    // A store landing in the same cycle as the hit must not cancel it;
    // a partial store to an unaligned ack address still acks.
    trig_a = {32'h0, 32'h3000}; en_a = 2'b01; mode_a = 2'b00;
    pc = 32'h3000; daddr = 32'h7F20; byteen = 4'hF;
    e_irq_a = 2'b01; e_cnt_a0 = 8'd1; e_busy_a = 1'b1; step("t4_hit_with_ack");
    byteen = 4'h0; step("t4_hold_on_trig");
    pc = 32'h0; step("t4_hold_off_trig");
    daddr = 32'h7F22; byteen = 4'b0100; e_irq_a = 2'b00; step("t4_ack_partial");
    byteen = 4'h0; e_busy_a = 1'b0; step("t4_retire");

    // Enable while the PC already sits on the trigger.
    trig_a = {32'h3100, 32'h3000}; en_a = 2'b00;
    pc = 32'h3100; step("t5_disabled");
    en_a = 2'b10; e_irq_a = 2'b10; e_cnt_a1 = 8'd1; e_busy_a = 1'b1;
    step("t5_enable_fire");
    daddr = 32'h7F24; byteen = 4'hF; e_irq_a = 2'b00; step("t5_ack");
    byteen = 4'h0; en_a = 2'b00; e_busy_a = 1'b0; step("t5_disable_retire");
    do_reset("reset4");

    // Reset while asserted, then a fresh fire after release.
    trig_a = {32'h0, 32'h3000}; en_a = 2'b01; mode_a = 2'b00;
    pc = 32'h3000; e_irq_a = 2'b01; e_cnt_a0 = 8'd1; e_busy_a = 1'b1;
    step("t6_rise");
    reset = 1'b1; clear_exp(); step("t6_reset_mid");
    reset = 1'b0; e_irq_a = 2'b01; e_cnt_a0 = 8'd1; e_busy_a = 1'b1;
    step("t6_refire");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
